// File: rtl/mrv1_icache.sv
// mrv1_icache: direct-mapped, read-only instruction cache answering ifetch
// requests. Hits answer one cycle after accept; misses refill a whole line
// word by word from a backing memory, then answer from the captured word.
module mrv1_icache #(
  parameter int NUM_LINES_P  = 16,
  parameter int LINE_WORDS_P = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        imem_req_vld_i,
  output logic        imem_req_rdy_o,
  input  logic [31:0] imem_req_addr_i,
  output logic        imem_resp_vld_o,
  output logic [31:0] imem_resp_data_o,
  output logic        mem_req_vld_o,
  input  logic        mem_req_rdy_i,
  output logic [31:0] mem_req_addr_o,
  input  logic        mem_resp_vld_i,
  input  logic [31:0] mem_resp_data_i,
  input  logic        flush_i
);
  localparam int idx_width_lp = $clog2(NUM_LINES_P);
  localparam int off_width_lp = $clog2(LINE_WORDS_P);
  localparam int tag_width_lp = 30 - idx_width_lp - off_width_lp;
  localparam logic [off_width_lp:0] line_cnt_lp = (off_width_lp+1)'(LINE_WORDS_P);
  localparam logic [off_width_lp:0] last_cnt_lp = (off_width_lp+1)'(LINE_WORDS_P - 1);

  typedef enum logic [1:0] {IDLE, REFILL, RESP} state_e;
  state_e state, state_next;

  logic [NUM_LINES_P-1:0]  valid;
  logic [tag_width_lp-1:0] tags [NUM_LINES_P];
  logic [31:0]             data_ram [NUM_LINES_P*LINE_WORDS_P];

  logic [31:2]             req_q;
  logic [off_width_lp:0]   req_cnt;
  logic [off_width_lp:0]   resp_cnt;
  logic                    flush_seen;
  logic [31:0]             cap_word;
  logic                    hit_vld_p1;
  logic [31:0]             ram_q_p1;

  logic [off_width_lp-1:0] in_off, q_off;
  logic [idx_width_lp-1:0] in_idx, q_idx;
  logic [tag_width_lp-1:0] in_tag, q_tag;
  logic                    accept, hit, mem_fire, fill, last_fill, capture;
  logic                    unused_addr_bits;

  assign in_off = imem_req_addr_i[2 +: off_width_lp];
  assign in_idx = imem_req_addr_i[2+off_width_lp +: idx_width_lp];
  assign in_tag = imem_req_addr_i[31 -: tag_width_lp];
  assign q_off  = req_q[2 +: off_width_lp];
  assign q_idx  = req_q[2+off_width_lp +: idx_width_lp];
  assign q_tag  = req_q[31 -: tag_width_lp];
  assign unused_addr_bits = ^imem_req_addr_i[1:0];

  assign hit       = valid[in_idx] && (tags[in_idx] == in_tag);
  assign accept    = imem_req_vld_i && imem_req_rdy_o;
  assign mem_fire  = mem_req_vld_o && mem_req_rdy_i;
  assign fill      = (state == REFILL) && mem_resp_vld_i;
  assign last_fill = fill && (resp_cnt == last_cnt_lp);
  assign capture   = fill && (resp_cnt[off_width_lp-1:0] == q_off);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state: a miss starts a refill, the last refill word leads to the answer
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && !hit) state_next = REFILL;
      REFILL:  if (last_fill) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: handshake, refill address stream and response mux
  always_comb begin
    imem_req_rdy_o   = 1'b0;
    mem_req_vld_o    = 1'b0;
    mem_req_addr_o   = 32'd0;
    imem_resp_vld_o  = hit_vld_p1;
    imem_resp_data_o = hit_vld_p1 ? ram_q_p1 : 32'd0;
    case (state)
      IDLE: imem_req_rdy_o = !flush_i && !rst_i;
      REFILL: begin
        if (req_cnt != line_cnt_lp) begin
          mem_req_vld_o  = 1'b1;
          mem_req_addr_o = {req_q[31:2+off_width_lp], req_cnt[off_width_lp-1:0], 2'b00};
        end
      end
      RESP: begin
        imem_resp_vld_o  = 1'b1;
        imem_resp_data_o = cap_word;
      end
      default: ;
    endcase
  end

  // Miss bookkeeping: latched request, issue/return counters, flush tracking
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q      <= '0;
      req_cnt    <= '0;
      resp_cnt   <= '0;
      flush_seen <= 1'b0;
      hit_vld_p1 <= 1'b0;
    end else begin
      hit_vld_p1 <= accept && hit;
      if (accept && !hit) begin
        req_q      <= imem_req_addr_i[31:2];
        req_cnt    <= '0;
        resp_cnt   <= '0;
        flush_seen <= 1'b0;
      end else if (state == REFILL) begin
        if (mem_fire) req_cnt <= req_cnt + 1'b1;
        if (fill)     resp_cnt <= resp_cnt + 1'b1;
        if (flush_i)  flush_seen <= 1'b1;
      end
    end
  end

  // Valid bits: flush wins over a completing fill
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                           valid <= '0;
    else if (flush_i)                    valid <= '0;
    else if (last_fill && !flush_seen)   valid[q_idx] <= 1'b1;
  end

  // Tag write on refill completion and capture of the requested word
  always_ff @(posedge clk_i) begin
    if (last_fill) tags[q_idx] <= q_tag;
    if (capture)   cap_word <= mem_resp_data_i;
  end

  // p0 -> p1: synchronous-read data array, written by refill words
  always_ff @(posedge clk_i) begin
    if (fill) data_ram[{q_idx, resp_cnt[off_width_lp-1:0]}] <= mem_resp_data_i;
    ram_q_p1 <= data_ram[{in_idx, in_off}];
  end
endmodule

// File: tb/tb_mrv1_icache.sv
// tb_mrv1_icache: directed vector table, hand-written corner sequences and a
// randomized phase, all checked against a transaction-level cache model.
module tb_mrv1_icache;
  localparam int LW = 4;
  localparam int NL = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_vld = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic        flush = 1'b0;
  logic        mem_rdy = 1'b0;
  logic        mem_rvld = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        req_rdy, resp_vld, mem_vld;
  logic [31:0] resp_data, mem_addr;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  mrv1_icache #(.NUM_LINES_P(NL), .LINE_WORDS_P(LW)) dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_vld_i(req_vld), .imem_req_rdy_o(req_rdy), .imem_req_addr_i(req_addr),
    .imem_resp_vld_o(resp_vld), .imem_resp_data_o(resp_data),
    .mem_req_vld_o(mem_vld), .mem_req_rdy_i(mem_rdy), .mem_req_addr_o(mem_addr),
    .mem_resp_vld_i(mem_rvld), .mem_resp_data_i(mem_rdata),
    .flush_i(flush)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Backing memory contents: distinct word for every word address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) + 32'h13572468;
  endfunction

  // ---------------- backing memory: in-order responder ----------------
  typedef struct { logic [31:0] addr; int ready; } mreq_t;
  mreq_t       mq[$];
  bit          rand_mode = 1'b0;
  int          stall_left = 0;
  logic [31:0] stall_addr = 32'd0;
  int          issued = 0;

  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      issued    = 0;
      mem_rvld  = 1'b0;
      mem_rdata = 32'd0;
      mem_rdy   = 1'b0;
    end else begin
      mem_rvld = 1'b0;
      if (mq.size() > 0 && mq[0].ready <= cyc && (!rand_mode || $urandom_range(3) != 0)) begin
        mem_rvld  = 1'b1;
        mem_rdata = mem_word(mq[0].addr);
        void'(mq.pop_front());
      end
      if (stall_left > 0 && mem_vld && (issued % LW) == 1) begin
        mem_rdy = 1'b0;
        stall_left--;
        check("stall_addr", mem_addr, stall_addr);
      end else begin
        mem_rdy = rand_mode ? ($urandom_range(2) != 0) : 1'b1;
      end
    end
    #1;
    if (!rst && mem_vld && mem_rdy) begin
      mq.push_back('{mem_addr, cyc + 1 + int'($urandom_range(2))});
      issued++;
    end
  end

  // ---------------- reference model and per-cycle monitor ----------------
  logic [31:0] exp_q[$];
  bit          busy = 1'b0;
  bit          flush_during = 1'b0;
  logic [31:0] miss_base = 32'd0;
  int          miss_idx = 0;
  int          issue_idx = 0;
  int          fill_cnt = 0;
  int          due_cyc = -1;
  int          hit_due = -1;
  logic [31:0] line_base [NL];
  bit          line_ok [NL];

  always @(negedge clk) begin : monitor
    logic [31:0] base;
    int          idx;
    bit          exp_resp;
    bit          exp_mvld;
    #1;
    if (rst) begin
      exp_q.delete();
      busy = 1'b0; flush_during = 1'b0;
      issue_idx = 0; fill_cnt = 0; due_cyc = -1; hit_due = -1;
      for (int i = 0; i < NL; i++) line_ok[i] = 1'b0;
    end else begin
      exp_resp = (cyc == hit_due) || (cyc == due_cyc);
      check("resp_vld", 32'(resp_vld), 32'(exp_resp));
      if (resp_vld) begin
        if (exp_q.size() == 0) check("resp_pending", 32'(exp_q.size()), 32'd1);
        else                   check("resp_data", resp_data, exp_q.pop_front());
      end
      check("req_rdy", 32'(req_rdy), 32'(!busy && !flush));
      if (cyc == due_cyc) begin
        busy = 1'b0;
        due_cyc = -1;
      end
      if (flush) begin
        for (int i = 0; i < NL; i++) line_ok[i] = 1'b0;
        if (busy) flush_during = 1'b1;
      end
      exp_mvld = busy && issue_idx < LW;
      check("mem_vld", 32'(mem_vld), 32'(exp_mvld));
      if (mem_vld && exp_mvld) begin
        check("mem_addr", mem_addr, miss_base + 32'(4 * issue_idx));
        if (mem_rdy) issue_idx++;
      end
      if (busy && due_cyc < 0 && mem_rvld) begin
        fill_cnt++;
        if (fill_cnt == LW) begin
          due_cyc = cyc + 1;
          if (!flush_during) begin
            line_ok[miss_idx]   = 1'b1;
            line_base[miss_idx] = miss_base;
          end
        end
      end
      if (req_vld && req_rdy) begin
        base = req_addr & ~32'(LW * 4 - 1);
        idx  = int'((req_addr / (LW * 4)) % NL);
        exp_q.push_back(mem_word(req_addr & ~32'd3));
        if (line_ok[idx] && line_base[idx] == base) begin
          hit_due = cyc + 1;
        end else begin
          busy = 1'b1; miss_base = base; miss_idx = idx;
          issue_idx = 0; fill_cnt = 0; flush_during = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_req(input logic [31:0] a);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    req_vld  = 1'b1;
    req_addr = a;
    for (int i = 0; i < 200; i++) begin
      #2;
      if (req_rdy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    req_vld = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    for (int i = 0; i < 300; i++) begin
      #2;
      if (resp_vld) return;
      @(negedge clk);
      lat++;
    end
    lat = -1;
    check("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_req(input logic [31:0] a, output bit hit);
    int lat;
    send_req(a);
    wait_resp(lat);
    hit = (lat == 1);
  endtask

  task automatic flush_pulse();
    @(negedge clk);
    flush = 1'b1;
    #2;
    check("flush_rdy", 32'(req_rdy), 32'd0);
    @(negedge clk);
    flush = 1'b0;
  endtask

  typedef struct { logic [31:0] addr; bit flush_first; bit exp_hit; } vec_t;
  vec_t vecs[12];

  initial begin
    bit hit;
    int lat;
    int n;
    vecs[0]  = '{32'h0000_0100, 1'b0, 1'b0};
    vecs[1]  = '{32'h0000_0104, 1'b0, 1'b1};
    vecs[2]  = '{32'h0000_010C, 1'b0, 1'b1};
    vecs[3]  = '{32'h0000_0500, 1'b0, 1'b0};
    vecs[4]  = '{32'h0000_0100, 1'b0, 1'b0};
    vecs[5]  = '{32'h0000_0108, 1'b0, 1'b1};
    vecs[6]  = '{32'h0000_0100, 1'b1, 1'b0};
    vecs[7]  = '{32'h0000_00F0, 1'b0, 1'b0};
    vecs[8]  = '{32'h0000_00F4, 1'b0, 1'b1};
    vecs[9]  = '{32'hFFFF_FFF8, 1'b0, 1'b0};
    vecs[10] = '{32'h0000_00FC, 1'b0, 1'b0};
    vecs[11] = '{32'h0000_0102, 1'b0, 1'b1};

    // Reset state, with a request already asserted
    rst = 1'b1;
    req_vld = 1'b1;
    req_addr = 32'h100;
    repeat (2) @(negedge clk);
    #2;
    check("rst_rdy", 32'(req_rdy), 32'd0);
    check("rst_resp_vld", 32'(resp_vld), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_mem_vld", 32'(mem_vld), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    req_vld = 1'b0;
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].flush_first) flush_pulse();
      do_req(vecs[i].addr, hit);
      check($sformatf("vec%0d_hit", i), 32'(hit), 32'(vecs[i].exp_hit));
    end

    // Back-to-back hits on the resident 0x100 line
    @(negedge clk); req_vld = 1'b1; req_addr = 32'h100;
    #2; check("b2b_rdy0", 32'(req_rdy), 32'd1);
    @(negedge clk); req_addr = 32'h104;
    #2; check("b2b_resp0", 32'(resp_vld), 32'd1); check("b2b_rdy1", 32'(req_rdy), 32'd1);
    @(negedge clk); req_addr = 32'h10C;
    #2; check("b2b_resp1", 32'(resp_vld), 32'd1); check("b2b_rdy2", 32'(req_rdy), 32'd1);
    @(negedge clk); req_vld = 1'b0;
    #2; check("b2b_resp2", 32'(resp_vld), 32'd1); check("b2b_no_mem", 32'(mem_vld), 32'd0);
    @(negedge clk);
    #2; check("b2b_quiet", 32'(resp_vld), 32'd0);

    // Backing-memory stall on the second refill word
    flush_pulse();
    stall_addr = 32'h104;
    stall_left = 5;
    do_req(32'h100, hit);
    check("stall_miss", 32'(hit), 32'd0);
    check("stall_consumed", 32'(stall_left), 32'd0);

    // Flush during a refill: still answered, line left invalid
    flush_pulse();
    send_req(32'h100);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    #2; check("midflush_rdy", 32'(req_rdy), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    wait_resp(lat);
    check("midflush_answered", 32'(lat > 0), 32'd1);
    do_req(32'h100, hit);
    check("midflush_then_miss", 32'(hit), 32'd0);
    do_req(32'h104, hit);
    check("midflush_refilled_hit", 32'(hit), 32'd1);

    // Reset in the middle of a refill
    flush_pulse();
    send_req(32'h100);
    n = 0;
    while (fill_cnt < 2 && n < 100) begin
      @(negedge clk); #2; n++;
    end
    check("rst_wait_fills", 32'(fill_cnt >= 2), 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_rdy", 32'(req_rdy), 32'd0);
    check("midrst_resp_vld", 32'(resp_vld), 32'd0);
    check("midrst_resp_data", resp_data, 32'd0);
    check("midrst_mem_vld", 32'(mem_vld), 32'd0);
    check("midrst_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_req(32'h100, hit);
    check("after_rst_miss", 32'(hit), 32'd0);

    // Randomized traffic against the model
    rand_mode = 1'b1;
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      req_vld  = ($urandom_range(2) != 0);
      req_addr = 32'($urandom_range(2)) * 32'h1000 + 32'($urandom_range(3)) * 32'd16
               + 32'($urandom_range(3)) * 32'd4 + 32'($urandom_range(3));
      flush    = ($urandom_range(40) == 0);
    end
    @(negedge clk);
    req_vld = 1'b0;
    flush = 1'b0;
    n = 0;
    while ((busy || exp_q.size() > 0) && n < 500) begin
      @(negedge clk); #2; n++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    check("drain_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
